// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory port of the
// unified memory arbiter. The arbiter connects through the slave modport.
interface rv32i_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and
// load/store; data has priority, a starvation counter forces fetch progress.
module rv32i_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    rv32i_mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_lat_cnt;
    logic [3:0]          r_starve_cnt;
    logic                r_owner_d;

    logic                r_if_gnt;
    logic                r_if_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_d_gnt;
    logic                r_d_rvalid;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;

    logic                w_force_if;
    logic                w_grant_d;
    logic                w_grant_if;
    logic [BE_W-1:0]     w_be_ones;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_ones
        assign w_be_ones[gi] = 1'b1;
    end

    // Requests are only looked at in IDLE; fetch wins once data has starved it long enough.
    assign w_force_if = bus.if_req && (r_starve_cnt == STARVE_LIM);
    assign w_grant_d  = (r_state == IDLE) && bus.d_req && !w_force_if;
    assign w_grant_if = (r_state == IDLE) && bus.if_req && !w_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_owner_d    <= 1'b0;
            r_if_gnt     <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_d_gnt      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // Strobes are single-cycle; buses keep their last value.
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_d_gnt     <= 1'b1;
                        r_owner_d   <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_be    <= bus.d_we ? bus.d_be : w_be_ones;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_lat_cnt   <= LAT_LOAD;
                        r_busy      <= 1'b1;
                        r_state     <= WAIT;
                        if (bus.if_req) begin
                            if (r_starve_cnt != STARVE_LIM) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end else if (w_grant_if) begin
                        r_if_gnt     <= 1'b1;
                        r_owner_d    <= 1'b0;
                        r_mem_en     <= 1'b1;
                        r_mem_be     <= w_be_ones;
                        r_mem_addr   <= bus.if_addr;
                        r_lat_cnt    <= LAT_LOAD;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= '0;
                        r_state      <= WAIT;
                    end
                end

                WAIT: begin
                    // Counter reaches zero in the cycle the memory presents its data.
                    if (r_lat_cnt == 3'd0) begin
                        if (r_owner_d) begin
                            r_d_rdata  <= bus.mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_if_rdata  <= bus.mem_rdata;
                            r_if_rvalid <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end

                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Shares one single-port unified instruction/data memory between the RV32I fetch stage and the load/store unit. Only one transaction is outstanding at a time. Data accesses have priority. A bounded-starvation counter guarantees fetch progress. All requester-side and memory-side outputs are registered.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits (byte enables are DATA_W/8)
MEM_LAT, 1, cycles from a mem_en cycle to the cycle mem_rdata is valid (legal range 1..7)
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced (legal range 1..15)

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address (word aligned)
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  store byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data (passes through mem_rdata for stores)
mem_en  out  1  one-cycle memory access strobe
mem_we  out  1  memory write enable
mem_be  out  DATA_W/8  memory byte enables (all ones for fetch/load)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever the state is not IDLE

Behaviour:
- State machine has three states: IDLE, WAIT, RESP.
- Reset: state = IDLE; starve_cnt = 0; every output is 0, including the data and address buses.
- IDLE: requests are sampled only in this state. If d_req and not force_if, grant data. Else if if_req, grant fetch. Else stay in IDLE.
- force_if = if_req && (starve_cnt == STARVE_MAX).
- Grant at edge E (the request was sampled in cycle T):
  - During cycle T+1, mem_en = 1 and xx_gnt = 1 for exactly one cycle.
  - mem_addr, mem_we, mem_be and mem_wdata are registered copies of the winner's inputs.
  - A fetch drives mem_we = 0 and mem_be = all ones.
  - Next state is WAIT, with the latency counter loaded to MEM_LAT.
- WAIT: decrement the counter each cycle. The cycle in which mem_rdata is valid is T+1+MEM_LAT. In that cycle, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP (cycle T+2+MEM_LAT):
  - xx_rvalid = 1 for one cycle, with xx_rdata stable.
  - Return to IDLE; the next request is sampled in the following cycle.
  - Minimum period is MEM_LAT+3 cycles per transaction.
- Output hold rules:
  - mem_en, mem_we and the gnt/rvalid strobes are 0 outside their defined cycles.
  - mem_addr, mem_be and mem_wdata hold their last value.
  - xx_rdata holds until the next capture for that requester.
- Requester rules:
  - Hold req and its payload stable until gnt.
  - req high in IDLE is always a new request; requesters drop or renew req after gnt.
  - req changes during WAIT/RESP are ignored.
- starve_cnt update:
  - Data grant while if_req = 1: increment, saturating at STARVE_MAX.
  - Data grant while if_req = 0: clear to 0.
  - Fetch grant: clear to 0.
- Both requests high in IDLE with force_if = 0: data wins. With force_if = 1: fetch wins.
- Reset asserted mid-transaction: immediate return to IDLE at that edge. The in-flight response is discarded (no rvalid), and all strobes are 0 in the next cycle.
- A store still produces d_rvalid as its completion pulse.

Test Plan:
- Lone fetch, MEM_LAT=1: if_req=1, if_addr=0x0000_0010 in cycle 0 → mem_en=1, mem_addr=0x10, if_gnt=1 in cycle 1; memory returns 0x0000_0093 in cycle 2; if_rvalid=1, if_rdata=0x0000_0093 in cycle 3; busy=1 in cycles 1–3.
- Contention: d_req (load 0x200) and if_req both high in cycle 0 → d_gnt in cycle 1. The fetch is granted at the first IDLE sample after d_rvalid. No simultaneous gnt pulses ever occur.
- Store: d_we=1, d_be=4'b0011, d_addr=0x104, d_wdata=0xDEADBEEF → one mem_en cycle with mem_we=1 and matching be/addr/wdata, then d_rvalid once; if_rvalid stays 0.
- Starvation, STARVE_MAX=4: d_req and if_req held high continuously → grant order D,D,D,D,F,D,D,D,D,F,…
- Reset during WAIT (MEM_LAT=3): reset pulsed in cycle 2 → no rvalid pulse; all outputs 0 in cycle 3; a fresh if_req is granted normally afterwards.
- Latency sweep: MEM_LAT=1 and MEM_LAT=7 → rvalid exactly MEM_LAT+1 cycles after gnt; back-to-back fetches spaced MEM_LAT+3 cycles apart.
